// File: rtl/frame_wr.sv
// Ingress frame writer: allocates blocks from the free list, writes frame bytes to packet memory, chains blocks and emits a descriptor.
// Optional build macro FRAME_WR_STALL_CNT_EN adds stall_cnt_o (saturating count of ungranted WAIT cycles).
//
// state  | meaning
// REQ    | one-cycle alloc request pulse
// WAIT   | sample grant; on grant load new block (and link it if a frame is open)
// STREAM | accept bytes into the current block
// DESC   | present descriptor until consumed
module frame_wr #(
  parameter int ADDR_W = 7,
  parameter int OFF_W  = 6,
  parameter int LEN_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  input  logic [7:0]              in_data_i,
  input  logic                    in_last_i,
  output logic                    in_ready_o,
  output logic                    alloc_req_o,
  input  logic                    alloc_gnt_i,
  input  logic [ADDR_W-1:0]       alloc_block_idx_i,
  output logic                    mem_we_o,
  output logic [ADDR_W+OFF_W-1:0] mem_addr_o,
  output logic [7:0]              mem_wdata_o,
  output logic                    link_we_o,
  output logic [ADDR_W-1:0]       link_addr_o,
  output logic [ADDR_W-1:0]       link_next_o,
  output logic                    desc_valid_o,
  output logic [ADDR_W-1:0]       desc_head_o,
  output logic [LEN_W-1:0]        desc_len_o,
  input  logic                    desc_ready_i
`ifdef FRAME_WR_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt_o
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, STREAM, DESC} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cur_q, cur_d;
  logic [ADDR_W-1:0]  prev_q, prev_d;
  logic [ADDR_W-1:0]  head_q, head_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               open_q, open_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      cur_q   <= '0;
      prev_q  <= '0;
      head_q  <= '0;
      off_q   <= '0;
      len_q   <= '0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      head_q  <= head_d;
      off_q   <= off_d;
      len_q   <= len_d;
      open_q  <= open_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    prev_d       = prev_q;
    head_d       = head_q;
    off_d        = off_q;
    len_d        = len_q;
    open_d       = open_q;
    in_ready_o   = 1'b0;
    alloc_req_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    link_we_o    = 1'b0;
    link_addr_o  = '0;
    link_next_o  = '0;
    desc_valid_o = 1'b0;
    desc_head_o  = '0;
    desc_len_o   = '0;

    case (state_q)
      REQ: begin
        // REQ is the reset state, so the pulse is masked while reset is held
        alloc_req_o = !rst;
        state_d     = WAIT;
      end
      WAIT: begin
        if (alloc_gnt_i) begin
          cur_d = alloc_block_idx_i;
          off_d = '0;
          if (open_q) begin
            link_we_o   = 1'b1;
            link_addr_o = prev_q;
            link_next_o = alloc_block_idx_i;
          end else begin
            head_d = alloc_block_idx_i;
            open_d = 1'b1;
          end
          state_d = STREAM;
        end else begin
          state_d = REQ;
        end
      end
      STREAM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = {cur_q, off_q};
          mem_wdata_o = in_data_i;
          off_d       = off_q + OFF_W'(1);
          len_d       = len_q + LEN_W'(1);
          if (in_last_i) begin
            link_we_o   = 1'b1;
            link_addr_o = cur_q;
            link_next_o = '0;
            state_d     = DESC;
          end else if (off_q == {OFF_W{1'b1}}) begin
            prev_d  = cur_q;
            state_d = REQ;
          end
        end
      end
      DESC: begin
        desc_valid_o = 1'b1;
        desc_head_o  = head_q;
        desc_len_o   = len_q;
        if (desc_ready_i) begin
          len_d   = '0;
          open_d  = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

`ifdef FRAME_WR_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == WAIT && !alloc_gnt_i && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  // Stall counter not present in this build.
`endif

endmodule

// File: tb/tb_frame_wr.sv
// Directed bench for frame_wr: cycle-exact vector table plus multi-cycle frame sequences.
module tb_frame_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [7:0]  in_data_i = '0;
  logic        in_last_i = 1'b0;
  logic        in_ready_o;
  logic        alloc_req_o;
  logic        alloc_gnt_i = 1'b0;
  logic [6:0]  alloc_block_idx_i = '0;
  logic        mem_we_o;
  logic [12:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        link_we_o;
  logic [6:0]  link_addr_o;
  logic [6:0]  link_next_o;
  logic        desc_valid_o;
  logic [6:0]  desc_head_o;
  logic [11:0] desc_len_o;
  logic        desc_ready_i = 1'b0;
`ifdef FRAME_WR_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  frame_wr dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
    .alloc_req_o(alloc_req_o), .alloc_gnt_i(alloc_gnt_i), .alloc_block_idx_i(alloc_block_idx_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .link_we_o(link_we_o), .link_addr_o(link_addr_o), .link_next_o(link_next_o),
    .desc_valid_o(desc_valid_o), .desc_head_o(desc_head_o), .desc_len_o(desc_len_o),
    .desc_ready_i(desc_ready_i)
`ifdef FRAME_WR_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        g;
    logic [6:0]  gi;
    logic        dr;
    logic [58:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;
  int consec = 0;
  int low_at [0:255];
  logic prev_req = 1'b0;
  logic auto_gnt = 1'b1;
  logic acc;
  int gq [$];
  logic [12:0] ma [$];
  logic [7:0]  md [$];
  logic [6:0]  la [$];
  logic [6:0]  ln [$];

  function automatic logic [58:0] outs();
    return {alloc_req_o, in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, link_we_o,
            link_addr_o, link_next_o, desc_valid_o, desc_head_o, desc_len_o};
  endfunction

  function automatic logic [58:0] ex(logic rq, logic rd, logic we, logic [12:0] a, logic [7:0] wd,
                                     logic lw, logic [6:0] lad, logic [6:0] lnx, logic dv,
                                     logic [6:0] dh, logic [11:0] dl);
    return {rq, rd, we, a, wd, lw, lad, lnx, dv, dh, dl};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    #1;
    if (mem_we_o) begin ma.push_back(mem_addr_o); md.push_back(mem_wdata_o); end
    if (link_we_o) begin la.push_back(link_addr_o); ln.push_back(link_next_o); end
    if (alloc_req_o) req_cnt++;
    if (alloc_req_o && prev_req) consec++;
    acc = in_valid_i && in_ready_o;
  endtask

  task automatic advance();
    prev_req = alloc_req_o;
    @(posedge clk);
    @(negedge clk);
    if (auto_gnt) begin
      alloc_gnt_i = 1'b0;
      alloc_block_idx_i = '0;
      if (prev_req && gq.size() > 0) begin
        int idx;
        idx = gq.pop_front();
        if (idx != 0) begin
          alloc_gnt_i = 1'b1;
          alloc_block_idx_i = 7'(idx);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    alloc_gnt_i = 1'b0; alloc_block_idx_i = '0; desc_ready_i = 1'b0;
    auto_gnt = 1'b1;
    gq.delete(); ma.delete(); md.delete(); la.delete(); ln.delete();
    prev_req = 1'b0; req_cnt = 0;
    for (int i = 0; i < 256; i++) low_at[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(int n, logic [7:0] base, logic do_last);
    int i = 0;
    int budget = 0;
    while (i < n && budget < 2000) begin
      in_valid_i = 1'b1;
      in_data_i  = base + 8'(i);
      in_last_i  = do_last && (i == n - 1);
      sample();
      if (!in_ready_o) low_at[i]++;
      if (acc) i++;
      advance();
      budget++;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    if (i < n) check("send_timeout", 64'(i), 64'(n));
  endtask

  initial begin
    vec_t tbl [11];
    int bad;
    int tot;
    logic [8:0] req_bits;
    logic [8:0] rdy_bits;

    // 1-byte frame (idx 5), then the next frame's head (idx 6) and a 2-byte frame
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b0, ex(1,0,0,13'd0,8'h00,0,7'd0,7'd0,0,7'd0,12'd0)};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 7'd5, 1'b0, ex(0,0,0,13'd0,8'h00,0,7'd0,7'd0,0,7'd0,12'd0)};
    tbl[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 7'd0, 1'b0, ex(0,1,1,13'd320,8'hA5,1,7'd5,7'd0,0,7'd0,12'd0)};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b0, ex(0,0,0,13'd0,8'h00,0,7'd0,7'd0,1,7'd5,12'd1)};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b1, ex(0,0,0,13'd0,8'h00,0,7'd0,7'd0,1,7'd5,12'd1)};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b0, ex(1,0,0,13'd0,8'h00,0,7'd0,7'd0,0,7'd0,12'd0)};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 7'd6, 1'b0, ex(0,0,0,13'd0,8'h00,0,7'd0,7'd0,0,7'd0,12'd0)};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b0, ex(0,1,0,13'd0,8'h00,0,7'd0,7'd0,0,7'd0,12'd0)};
    tbl[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 7'd0, 1'b0, ex(0,1,1,13'd384,8'h3C,0,7'd0,7'd0,0,7'd0,12'd0)};
    tbl[9]  = '{1'b1, 8'h11, 1'b1, 1'b0, 7'd0, 1'b0, ex(0,1,1,13'd385,8'h11,1,7'd6,7'd0,0,7'd0,12'd0)};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b0, ex(0,0,0,13'd0,8'h00,0,7'd0,7'd0,1,7'd6,12'd2)};

    do_reset();
    auto_gnt = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid_i = tbl[i].v; in_data_i = tbl[i].d; in_last_i = tbl[i].l;
      alloc_gnt_i = tbl[i].g; alloc_block_idx_i = tbl[i].gi; desc_ready_i = tbl[i].dr;
      sample();
      check($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
      advance();
    end

    // 64-byte frame in one block; descriptor held 10 cycles
    do_reset();
    gq.push_back(3);
    gq.push_back(8);
    send_frame(64, 8'h00, 1'b1);
    check("b64_req_cnt", 64'(req_cnt), 64'd1);
    check("b64_mem_cnt", 64'(ma.size()), 64'd64);
    if (ma.size() == 64) begin
      check("b64_last_addr", 64'(ma[63]), 64'd255);
      check("b64_last_data", 64'(md[63]), 64'd63);
    end
    check("b64_link_cnt", 64'(la.size()), 64'd1);
    if (la.size() == 1) check("b64_link", 64'({la[0], ln[0]}), 64'({7'd3, 7'd0}));
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (!(desc_valid_o && desc_head_o == 7'd3 && desc_len_o == 12'd64 && !in_ready_o && !alloc_req_o))
        bad++;
      advance();
    end
    check("b64_desc_hold", 64'(bad), 64'd0);
    desc_ready_i = 1'b1;
    sample();
    advance();
    desc_ready_i = 1'b0;
    sample();
    check("b64_req_after_desc", 64'(alloc_req_o), 64'd1);
    check("b64_req_cnt2", 64'(req_cnt), 64'd2);
    advance();

    // 130-byte frame over three blocks
    do_reset();
    gq.push_back(2); gq.push_back(7); gq.push_back(9);
    send_frame(130, 8'h40, 1'b1);
    check("b130_link_cnt", 64'(la.size()), 64'd3);
    if (la.size() == 3)
      check("b130_links", 64'({la[0], ln[0], la[1], ln[1], la[2], ln[2]}),
            64'({7'd2, 7'd7, 7'd7, 7'd9, 7'd9, 7'd0}));
    if (ma.size() == 130) begin
      check("b130_addr64", 64'(ma[64]), 64'd448);
      check("b130_addr129", 64'(ma[129]), 64'd577);
    end else begin
      check("b130_mem_cnt", 64'(ma.size()), 64'd130);
    end
    check("b130_bubble64", 64'(low_at[64]), 64'd2);
    check("b130_bubble128", 64'(low_at[128]), 64'd2);
    tot = 0;
    for (int i = 1; i < 130; i++) tot += low_at[i];
    check("b130_bubble_total", 64'(tot), 64'd4);
    sample();
    check("b130_desc", 64'({desc_valid_o, desc_head_o, desc_len_o}), 64'({1'b1, 7'd2, 12'd130}));
    desc_ready_i = 1'b1;
    advance();
    desc_ready_i = 1'b0;

    // Empty free list for three attempts, then grant 4
    do_reset();
    gq.push_back(0); gq.push_back(0); gq.push_back(0); gq.push_back(4);
    req_bits = '0;
    rdy_bits = '0;
    for (int c = 0; c < 9; c++) begin
      sample();
      req_bits = {req_bits[7:0], alloc_req_o};
      rdy_bits = {rdy_bits[7:0], in_ready_o};
      advance();
    end
    check("empty_req_pattern", 64'(req_bits), 64'(9'b101010100));
    check("empty_ready_pattern", 64'(rdy_bits), 64'(9'b000000001));
`ifdef FRAME_WR_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt_o), 64'd3);
`endif

    // Reset at byte 20 drops the partial frame
    do_reset();
    gq.push_back(2);
    send_frame(20, 8'h80, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_outputs_zero", 64'(outs()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    gq.delete(); ma.delete(); la.delete(); ln.delete();
    prev_req = 1'b0;
    gq.push_back(6);
    sample();
    check("rst_first_req", 64'(alloc_req_o), 64'd1);
    advance();
    send_frame(5, 8'h10, 1'b1);
    sample();
    check("rst_new_desc", 64'({desc_valid_o, desc_head_o, desc_len_o}), 64'({1'b1, 7'd6, 12'd5}));
    check("rst_mem_first", 64'(ma.size() > 0 ? ma[0] : 13'h1FFF), 64'(13'd384));
    advance();

    check("no_consec_req", 64'(consec), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
